// File: rtl/l2_memory_responder_if.sv
// L2 memory interface: request channel, write-data channel and read-response
// channel between the L2 arbiter (master) and a memory backend (slave).
`timescale 1ns/1ps
interface l2_memory_interface #(
  parameter int L2_ID_W = 4
);
  logic [29:0]        addr;
  logic               rnw;
  logic               is_amo;
  logic [4:0]         amo_type_or_burst_size;
  logic [L2_ID_W-1:0] id;
  logic               request_valid;
  logic               abort;
  logic               request_pop;

  logic [31:0]        wr_data;
  logic [3:0]         wr_data_be;
  logic               wr_data_valid;
  logic               wr_data_read;
  logic               wr_complete;

  logic [31:0]        rd_data;
  logic [L2_ID_W-1:0] rd_id;
  logic               rd_data_valid;

  modport master (
    output addr, rnw, is_amo, amo_type_or_burst_size, id, request_valid, abort,
    output wr_data, wr_data_be, wr_data_valid,
    input  request_pop, wr_data_read, wr_complete, rd_data, rd_id, rd_data_valid
  );

  modport slave (
    input  addr, rnw, is_amo, amo_type_or_burst_size, id, request_valid, abort,
    input  wr_data, wr_data_be, wr_data_valid,
    output request_pop, wr_data_read, wr_complete, rd_data, rd_id, rd_data_valid
  );
endinterface

// File: rtl/l2_memory_responder.sv
// L2 memory responder: serves serialised single/burst reads and writes from
// an on-chip word-addressed RAM. Burst addresses wrap at the RAM end, AMO
// requests run as plain accesses and set a sticky error flag.
`timescale 1ns/1ps
module l2_memory_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int L2_ID_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  l2_memory_interface.slave l2,
  output logic             amo_err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   base_r;
  logic [4:0]         size_r;
  logic [4:0]         cnt_r;
  logic [L2_ID_W-1:0] id_r;
  logic [31:0]        rd_data_r;
  logic [L2_ID_W-1:0] rd_id_r;
  logic               rd_data_valid_r;
  logic               wr_complete_r;
  logic               amo_err_r;

  logic [31:0]        mem_r [DEPTH_WORDS];

  logic [IDX_W-1:0]   idx_s;
  logic               last_s;
  logic               pop_s;
  logic               wr_accept_s;
  logic               ram_we_s;
  logic               unused_addr_s;

  // Upper address bits alias onto the RAM and are deliberately ignored.
  assign unused_addr_s = ^l2.addr[29:IDX_W];

  // Current word index, last-word detect and the combinational handshakes.
  always_comb begin
    idx_s       = base_r + IDX_W'(cnt_r);
    last_s      = (cnt_r == size_r);
    pop_s       = 1'b0;
    wr_accept_s = 1'b0;
    case (state_r)
      IDLE:         pop_s       = l2.request_valid;
      WRITE, DRAIN: wr_accept_s = l2.wr_data_valid;
      default: begin
        pop_s       = 1'b0;
        wr_accept_s = 1'b0;
      end
    endcase
    if (state_r == WRITE) begin
      ram_we_s = wr_accept_s;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // Request FSM with registered response, completion and error outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      base_r          <= '0;
      size_r          <= 5'd0;
      cnt_r           <= 5'd0;
      id_r            <= '0;
      rd_data_r       <= 32'd0;
      rd_id_r         <= '0;
      rd_data_valid_r <= 1'b0;
      wr_complete_r   <= 1'b0;
      amo_err_r       <= 1'b0;
    end else begin
      rd_data_valid_r <= 1'b0;
      wr_complete_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            base_r <= l2.addr[IDX_W-1:0];
            id_r   <= l2.id;
            size_r <= l2.amo_type_or_burst_size;
            cnt_r  <= 5'd0;
            if (l2.is_amo) begin
              amo_err_r <= 1'b1;
            end
            if (l2.abort) begin
              // A discarded write still has its data words to swallow.
              state_r <= l2.rnw ? IDLE : DRAIN;
            end else begin
              state_r <= l2.rnw ? READ : WRITE;
            end
          end
        end
        READ: begin
          rd_data_r       <= mem_r[idx_s];
          rd_id_r         <= id_r;
          rd_data_valid_r <= 1'b1;
          if (last_s) begin
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end
        WRITE: begin
          if (wr_accept_s) begin
            if (last_s) begin
              wr_complete_r <= 1'b1;
              state_r       <= IDLE;
            end else begin
              cnt_r <= cnt_r + 5'd1;
            end
          end
        end
        DRAIN: begin
          if (wr_accept_s) begin
            if (last_s) begin
              state_r <= IDLE;
            end else begin
              cnt_r <= cnt_r + 5'd1;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Byte-enabled RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (l2.wr_data_be[b]) begin
          mem_r[idx_s][8*b +: 8] <= l2.wr_data[8*b +: 8];
        end
      end
    end
  end

  assign l2.request_pop   = pop_s;
  assign l2.wr_data_read  = wr_accept_s;
  assign l2.wr_complete   = wr_complete_r;
  assign l2.rd_data       = rd_data_r;
  assign l2.rd_id         = rd_id_r;
  assign l2.rd_data_valid = rd_data_valid_r;
  assign amo_err          = amo_err_r;
endmodule

// File: tb/tb_l2_memory_responder.sv
// Scoreboard bench for l2_memory_responder: stimulus tasks push expected read
// words and wr_complete cycles; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_l2_memory_responder;
  localparam int DEPTH = 256;
  localparam int IDW   = 4;

  typedef struct {
    logic [31:0]    data;
    logic [IDW-1:0] id;
    int             when;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic amo_err;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   t_pop = 0;
  int   t1    = 0;

  rd_exp_t     rd_q[$];
  int          wc_q[$];
  logic [31:0] wdata [32];
  logic [3:0]  wbe   [32];
  logic [31:0] exp_w [32];

  l2_memory_interface #(.L2_ID_W(IDW)) l2 ();

  l2_memory_responder #(.DEPTH_WORDS(DEPTH), .L2_ID_W(IDW)) dut (
    .clk(clk), .rst(rst), .l2(l2), .amo_err(amo_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare every read beat and wr_complete pulse against the queues.
  always @(negedge clk) begin
    rd_exp_t e;
    int      w;
    if (l2.rd_data_valid) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 32'd1, 32'd0);
      end else begin
        e = rd_q.pop_front();
        check("rd_data", l2.rd_data, e.data);
        check("rd_id", 32'(l2.rd_id), 32'(e.id));
        check("rd_cycle", cyc, e.when);
      end
    end
    if (l2.wr_complete) begin
      if (wc_q.size() == 0) begin
        check("wc_unexpected", 32'd1, 32'd0);
      end else begin
        w = wc_q.pop_front();
        check("wc_cycle", cyc, w);
      end
    end
  end

  task automatic issue_req(input logic [29:0] addr, input logic rnw, input logic [4:0] bsz,
                           input logic [IDW-1:0] id, input logic amo, input logic abt);
    int n = 0;
    @(negedge clk);
    l2.addr = addr; l2.rnw = rnw; l2.amo_type_or_burst_size = bsz;
    l2.id = id; l2.is_amo = amo; l2.abort = abt; l2.request_valid = 1'b1;
    #1;
    while (!l2.request_pop && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check("pop_seen", 32'(l2.request_pop), 32'd1);
    t_pop = cyc;
    @(posedge clk); #1;
    l2.request_valid = 1'b0; l2.abort = 1'b0; l2.is_amo = 1'b0;
  endtask

  task automatic read_req(input logic [29:0] addr, input logic [4:0] bsz,
                          input logic [IDW-1:0] id, input logic amo, input int n_exp);
    issue_req(addr, 1'b1, bsz, id, amo, 1'b0);
    for (int i = 0; i < n_exp; i++) begin
      rd_q.push_back('{data: exp_w[i], id: id, when: t_pop + 2 + i});
    end
  endtask

  task automatic write_req(input logic [29:0] addr, input logic [4:0] bsz,
                           input logic [IDW-1:0] id, input logic abt, input logic gaps);
    int last_acc = 0;
    issue_req(addr, 1'b0, bsz, id, 1'b0, abt);
    for (int i = 0; i <= int'(bsz); i++) begin
      if (gaps && i > 0) begin
        @(negedge clk);
        l2.wr_data_valid = 1'b0;
        #1 check("wr_read_gap", 32'(l2.wr_data_read), 32'd0);
      end
      @(negedge clk);
      l2.wr_data = wdata[i]; l2.wr_data_be = wbe[i]; l2.wr_data_valid = 1'b1;
      #1 check("wr_data_read", 32'(l2.wr_data_read), 32'd1);
      last_acc = cyc;
    end
    if (!abt) wc_q.push_back(last_acc + 1);
    @(negedge clk);
    l2.wr_data_valid = 1'b0;
  endtask

  task automatic wait_drained();
    int n = 0;
    while ((rd_q.size() != 0 || wc_q.size() != 0) && n < 100) begin
      @(negedge clk); n++;
    end
    check("drained", 32'(rd_q.size() + wc_q.size()), 32'd0);
  endtask

  initial begin
    l2.addr = 30'd0; l2.rnw = 1'b0; l2.is_amo = 1'b0; l2.amo_type_or_burst_size = 5'd0;
    l2.id = '0; l2.request_valid = 1'b0; l2.abort = 1'b0;
    l2.wr_data = 32'd0; l2.wr_data_be = 4'd0; l2.wr_data_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      wdata[i] = 32'd0; wbe[i] = 4'hF; exp_w[i] = 32'd0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rd_valid", 32'(l2.rd_data_valid), 32'd0);
    check("rst_wc", 32'(l2.wr_complete), 32'd0);
    check("rst_amo_err", 32'(amo_err), 32'd0);
    check("rst_rd_data", l2.rd_data, 32'd0);
    check("rst_pop", 32'(l2.request_pop), 32'd0);
    rst = 1'b0;

    // Single-word write and readback
    wdata[0] = 32'hDEADBEEF; wbe[0] = 4'hF;
    write_req(30'h10, 5'd0, 4'd1, 1'b0, 1'b0);
    exp_w[0] = 32'hDEADBEEF;
    read_req(30'h10, 5'd0, 4'd2, 1'b0, 1);
    wait_drained();

    // 8-word burst write with valid gaps, then burst read
    for (int i = 0; i < 8; i++) begin
      wdata[i] = 32'(i); wbe[i] = 4'hF; exp_w[i] = 32'(i);
    end
    write_req(30'h20, 5'd7, 4'd3, 1'b0, 1'b1);
    read_req(30'h20, 5'd7, 4'd4, 1'b0, 8);
    wait_drained();

    // Byte-enable merge
    wdata[0] = 32'hFFFFFFFF; wbe[0] = 4'hF;
    write_req(30'h30, 5'd0, 4'd5, 1'b0, 1'b0);
    wdata[0] = 32'h00001200; wbe[0] = 4'h2;
    write_req(30'h30, 5'd0, 4'd5, 1'b0, 1'b0);
    exp_w[0] = 32'hFFFF12FF;
    read_req(30'h30, 5'd0, 4'd6, 1'b0, 1);
    wait_drained();

    // Wrap at RAM end, back-to-back read through an aliased address
    for (int i = 0; i < 4; i++) begin
      wdata[i] = 32'hCAFE0000 + 32'(i); wbe[i] = 4'hF; exp_w[i] = 32'hCAFE0000 + 32'(i);
    end
    write_req(30'(DEPTH - 2), 5'd3, 4'd7, 1'b0, 1'b0);
    read_req(30'(DEPTH - 2), 5'd3, 4'd8, 1'b0, 4);
    t1 = t_pop;
    exp_w[0] = 32'hDEADBEEF;
    read_req(30'(DEPTH + 16), 5'd0, 4'd9, 1'b0, 1);
    check("b2b_pop", t_pop, t1 + 5);
    exp_w[0] = 32'hCAFE0002; exp_w[1] = 32'hCAFE0003;
    read_req(30'h0, 5'd1, 4'd10, 1'b0, 2);
    wait_drained();

    // Aborted write drains 2 words and leaves RAM untouched
    wdata[0] = 32'h11111111; wdata[1] = 32'h22222222; wbe[0] = 4'hF; wbe[1] = 4'hF;
    write_req(30'h10, 5'd1, 4'd11, 1'b1, 1'b0);
    exp_w[0] = 32'hDEADBEEF;
    read_req(30'h10, 5'd0, 4'd12, 1'b0, 1);
    wait_drained();
    check("amo_err_clear", 32'(amo_err), 32'd0);

    // Aborted read stays IDLE; AMO read returns data and sets amo_err
    issue_req(30'h20, 1'b1, 5'd7, 4'd13, 1'b0, 1'b1);
    t1 = t_pop;
    exp_w[0] = 32'd0;
    read_req(30'h20, 5'd0, 4'd14, 1'b1, 1);
    check("abort_read_idle", t_pop, t1 + 1);
    wait_drained();
    check("amo_err_set", 32'(amo_err), 32'd1);
    repeat (5) @(negedge clk);
    check("amo_err_sticky", 32'(amo_err), 32'd1);

    // Reset during a 16-word read: only words 0..2 come back
    exp_w[0] = 32'd0; exp_w[1] = 32'd1; exp_w[2] = 32'd2;
    read_req(30'h20, 5'd15, 4'd15, 1'b0, 3);
    while (cyc < t_pop + 4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid_valid", 32'(l2.rd_data_valid), 32'd0);
    check("rst_mid_amo_err", 32'(amo_err), 32'd0);
    @(negedge clk);
    check("rst_mid_valid2", 32'(l2.rd_data_valid), 32'd0);
    rst = 1'b0;
    exp_w[0] = 32'hFFFF12FF;
    read_req(30'h30, 5'd0, 4'd1, 1'b0, 1);
    wait_drained();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
